// File: rtl/lcd_score_buffer_if.sv
// Score stream from the BNN output layer into the LCD score buffer.
interface lcd_score_buffer_if #(
  parameter int unsigned SCORE_W = 16
) ();
  logic               s_valid;
  logic               s_ready;
  logic [SCORE_W-1:0] s_score;
  logic               s_last;

  modport master (output s_valid, output s_score, output s_last, input s_ready);
  modport slave  (input s_valid, input s_score, input s_last, output s_ready);
endinterface

// File: rtl/lcd_score_buffer.sv
// Collects one frame of class scores, saturates them to display digits, and
// runs the LCD controller through one clear-and-display pass per frame.
module lcd_score_buffer #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned DIGIT_W     = 5,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  lcd_score_buffer_if.slave                    s,
  output logic [NUM_CLASSES-1:0][DIGIT_W-1:0]  values,
  output logic                                 lcd_rst,
  output logic                                 lcd_en,
  input  logic                                 lcd_done,
  output logic                                 busy,
  output logic [3:0]                           argmax,
  output logic                                 frame_err,
  output logic                                 timeout
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SCORE_W-1:0] DIGIT_MAX = SCORE_W'((2 ** DIGIT_W) - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT    = 2'd2
  } state_t;

  state_t                              state;
  logic [IDX_W-1:0]                    idx;
  logic [NUM_CLASSES-1:0][DIGIT_W-1:0] shadow;
  logic [SCORE_W-1:0]                  max_val;
  logic [IDX_W-1:0]                    max_idx;
  logic [CNT_W-1:0]                    cnt;

  logic               xfer;
  logic [DIGIT_W-1:0] digit;
  logic               take_max;

  // Incoming digit saturation and running-max update decision.
  always_comb begin
    xfer     = 1'b0;
    digit    = '0;
    take_max = 1'b0;
    xfer     = s.s_valid && s.s_ready;
    digit    = (s.s_score > DIGIT_MAX) ? DIGIT_W'(DIGIT_MAX) : s.s_score[DIGIT_W-1:0];
    take_max = (idx == '0) || (s.s_score > max_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_COLLECT;
      idx       <= '0;
      shadow    <= '0;
      max_val   <= '0;
      max_idx   <= '0;
      cnt       <= '0;
      values    <= '0;
      lcd_rst   <= 1'b0;
      lcd_en    <= 1'b0;
      busy      <= 1'b0;
      argmax    <= '0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      s.s_ready <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      lcd_rst   <= 1'b0;
      case (state)
        ST_COLLECT: begin
          s.s_ready <= 1'b1;
          if (xfer) begin
            shadow[idx] <= digit;
            if (take_max) begin
              max_val <= s.s_score;
              max_idx <= idx;
            end
            if (idx == LAST_IDX) begin
              // Frame is complete on the last slot regardless of s_last.
              frame_err <= !s.s_last;
              idx       <= '0;
              s.s_ready <= 1'b0;
              busy      <= 1'b1;
              state     <= ST_LOAD;
            end else if (s.s_last) begin
              frame_err <= 1'b1;
              idx       <= '0;
              max_val   <= '0;
              max_idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_LOAD: begin
          values  <= shadow;
          argmax  <= max_idx;
          lcd_rst <= 1'b1;
          lcd_en  <= 1'b1;
          cnt     <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lcd_done) begin
            lcd_en    <= 1'b0;
            busy      <= 1'b0;
            s.s_ready <= 1'b1;
            state     <= ST_COLLECT;
          end else if (cnt == CNT_LAST) begin
            lcd_en    <= 1'b0;
            timeout   <= 1'b1;
            busy      <= 1'b0;
            s.s_ready <= 1'b1;
            state     <= ST_COLLECT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_score_buffer.sv
// Randomized self-checking bench for lcd_score_buffer against a frame-level model.
module tb_lcd_score_buffer;

  localparam int unsigned NC = 10;
  localparam int unsigned SW = 16;
  localparam int unsigned DW = 5;
  localparam int unsigned TO = 1024;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     lcd_done;
  logic [NC-1:0][DW-1:0]    values;
  logic                     lcd_rst;
  logic                     lcd_en;
  logic                     busy;
  logic [3:0]               argmax;
  logic                     frame_err;
  logic                     timeout;

  lcd_score_buffer_if #(.SCORE_W(SW)) sif ();

  lcd_score_buffer #(
    .NUM_CLASSES(NC), .SCORE_W(SW), .DIGIT_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .s(sif), .values(values), .lcd_rst(lcd_rst),
    .lcd_en(lcd_en), .lcd_done(lcd_done), .busy(busy), .argmax(argmax),
    .frame_err(frame_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef logic [SW-1:0] frame_t [NC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Display digit is the score clamped to the largest 5-bit value.
  function automatic logic [NC-1:0][DW-1:0] model_digits(input frame_t sc);
    logic [NC-1:0][DW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i] = (sc[i] >= 32) ? DW'(31) : DW'(sc[i]);
    return r;
  endfunction

  // First index holding the largest raw score.
  function automatic logic [3:0] model_argmax(input frame_t sc);
    int best;
    best = 0;
    for (int i = 1; i < NC; i++) if (sc[i] > sc[best]) best = i;
    return 4'(best);
  endfunction

  task automatic gen_frame(output frame_t sc);
    for (int i = 0; i < NC; i++)
      sc[i] = ($urandom_range(3, 0) == 0) ? SW'($urandom()) : SW'($urandom_range(40, 1));
  endtask

  task automatic drive_scores(input frame_t sc, input int n, input int last_pos,
                              input int gap_max, output bit stalled);
    stalled = 1'b0;
    for (int i = 0; i < n; i++) begin
      int gap;
      int w;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) step();
      sif.s_valid = 1'b1;
      sif.s_score = sc[i];
      sif.s_last  = (i == last_pos);
      w = 0;
      while (!sif.s_ready && w < 2000) begin
        step();
        w++;
      end
      if (w >= 2000) stalled = 1'b1;
      step();
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
    end
  endtask

  // Called just after the completing edge; walks LOAD/WAIT and answers with lcd_done.
  task automatic show_frame(input int done_delay, output logic [NC-1:0][DW-1:0] v,
                            output logic [3:0] am, output logic rst_ok,
                            output logic en_after, output logic rdy_after,
                            output logic leak);
    logic rst_seen;
    step();
    v        = values;
    am       = argmax;
    rst_seen = lcd_rst;
    leak     = sif.s_ready;
    step();
    rst_ok   = rst_seen && !lcd_rst && lcd_en;
    repeat (done_delay) begin
      if (sif.s_ready || !lcd_en) leak = 1'b1;
      step();
    end
    lcd_done = 1'b1;
    step();
    en_after  = lcd_en;
    rdy_after = sif.s_ready;
    lcd_done  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    sif.s_score = '0;
    lcd_done    = 1'b0;
    repeat (3) step();
    checks++;
    if (sif.s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ready_busy got ready=%b busy=%b exp 0 0", sif.s_ready, busy);
    end
    checks++;
    if (values !== '0 || argmax !== 4'd0) begin
      errors++; $display("FAIL reset_values got %h/%0d exp 0/0", values, argmax);
    end
    checks++;
    if ({lcd_rst, lcd_en, frame_err, timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {lcd_rst, lcd_en, frame_err, timeout});
    end
    rst = 1'b0;
    step();
    checks++;
    if (sif.s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b exp 1", sif.s_ready);
    end
  endtask

  task automatic test_basic();
    frame_t sc;
    bit st;
    logic [NC-1:0][DW-1:0] v;
    logic [3:0] am;
    logic rok, ena, rdy, lk;
    for (int i = 0; i < NC; i++) sc[i] = SW'(i);
    drive_scores(sc, NC, NC - 1, 0, st);
    checks++;
    if (st || sif.s_ready !== 1'b0 || busy !== 1'b1 || lcd_en !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL basic_complete got st=%b rdy=%b busy=%b en=%b ferr=%b exp 0 0 1 0 0",
                         st, sif.s_ready, busy, lcd_en, frame_err);
    end
    show_frame(18, v, am, rok, ena, rdy, lk);
    checks++;
    if (v !== model_digits(sc)) begin
      errors++; $display("FAIL basic_values got %h exp %h", v, model_digits(sc));
    end
    checks++;
    if (am !== 4'd9) begin
      errors++; $display("FAIL basic_argmax got %0d exp 9", am);
    end
    checks++;
    if (rok !== 1'b1 || lk !== 1'b0) begin
      errors++; $display("FAIL basic_lcd_rst_pulse got ok=%b leak=%b exp 1 0", rok, lk);
    end
    checks++;
    if (ena !== 1'b0 || rdy !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_release got en=%b rdy=%b busy=%b exp 0 1 0", ena, rdy, busy);
    end
    step();
    checks++;
    if (values !== model_digits(sc)) begin
      errors++; $display("FAIL basic_values_hold got %h exp %h", values, model_digits(sc));
    end
  endtask

  task automatic test_saturation();
    frame_t sc;
    bit st;
    logic [NC-1:0][DW-1:0] v;
    logic [3:0] am;
    logic rok, ena, rdy, lk;
    sc = '{16'd5, 16'd40, 16'd40, 16'd3, 16'd100, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7};
    drive_scores(sc, NC, NC - 1, 2, st);
    show_frame(3, v, am, rok, ena, rdy, lk);
    checks++;
    if (v !== model_digits(sc) || v[1] !== 5'd31 || v[4] !== 5'd31) begin
      errors++; $display("FAIL sat_values got %h exp %h", v, model_digits(sc));
    end
    checks++;
    if (am !== 4'd4) begin
      errors++; $display("FAIL sat_argmax got %0d exp 4", am);
    end
    sc[4] = 16'd10;
    drive_scores(sc, NC, NC - 1, 2, st);
    show_frame(0, v, am, rok, ena, rdy, lk);
    checks++;
    if (am !== 4'd1 || v !== model_digits(sc)) begin
      errors++; $display("FAIL tie_argmax got %0d/%h exp 1/%h", am, v, model_digits(sc));
    end
  endtask

  task automatic test_early_last();
    frame_t sc;
    bit st;
    logic [NC-1:0][DW-1:0] v, prev;
    logic [3:0] am;
    logic rok, ena, rdy, lk;
    prev = values;
    gen_frame(sc);
    drive_scores(sc, 4, 3, 0, st);
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || sif.s_ready !== 1'b1) begin
      errors++; $display("FAIL early_last_err got ferr=%b busy=%b rdy=%b exp 1 0 1",
                         frame_err, busy, sif.s_ready);
    end
    step();
    checks++;
    if (frame_err !== 1'b0 || lcd_en !== 1'b0 || values !== prev) begin
      errors++; $display("FAIL early_last_pulse got ferr=%b en=%b exp 0 0 (values kept)", frame_err, lcd_en);
    end
    gen_frame(sc);
    drive_scores(sc, NC, NC - 1, 1, st);
    show_frame(5, v, am, rok, ena, rdy, lk);
    checks++;
    if (v !== model_digits(sc) || am !== model_argmax(sc)) begin
      errors++; $display("FAIL early_last_next got %h/%0d exp %h/%0d",
                         v, am, model_digits(sc), model_argmax(sc));
    end
  endtask

  task automatic test_no_last();
    frame_t sc;
    bit st;
    logic [NC-1:0][DW-1:0] v;
    logic [3:0] am;
    logic rok, ena, rdy, lk;
    gen_frame(sc);
    drive_scores(sc, NC, -1, 0, st);
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL no_last_err got ferr=%b busy=%b exp 1 1", frame_err, busy);
    end
    show_frame(2, v, am, rok, ena, rdy, lk);
    checks++;
    if (v !== model_digits(sc) || am !== model_argmax(sc) || rok !== 1'b1) begin
      errors++; $display("FAIL no_last_display got %h/%0d rst_ok=%b exp %h/%0d 1",
                         v, am, rok, model_digits(sc), model_argmax(sc));
    end
  endtask

  task automatic test_back_to_back();
    frame_t sc;
    bit st;
    logic [NC-1:0][DW-1:0] v;
    logic [3:0] am;
    logic rok, ena, rdy, lk;
    for (int f = 0; f < 6; f++) begin
      gen_frame(sc);
      if (f == 2) for (int i = 0; i < NC; i++) sc[i] = SW'(7);
      drive_scores(sc, NC, NC - 1, (f % 2 == 0) ? 3 : 0, st);
      show_frame(int'($urandom_range(12, 0)), v, am, rok, ena, rdy, lk);
      checks++;
      if (st || v !== model_digits(sc) || am !== model_argmax(sc)) begin
        errors++; $display("FAIL frame%0d_values got %h/%0d exp %h/%0d",
                           f, v, am, model_digits(sc), model_argmax(sc));
      end
      checks++;
      if (lk !== 1'b0 || ena !== 1'b0 || rdy !== 1'b1) begin
        errors++; $display("FAIL frame%0d_handshake got leak=%b en=%b rdy=%b exp 0 0 1",
                           f, lk, ena, rdy);
      end
    end
  endtask

  task automatic test_timeout();
    frame_t sc;
    bit st;
    int cnt;
    logic [NC-1:0][DW-1:0] v;
    logic [3:0] am;
    logic rok, ena, rdy, lk;
    gen_frame(sc);
    drive_scores(sc, NC, NC - 1, 0, st);
    step();
    cnt = 0;
    while (lcd_en && cnt < 3000) begin
      cnt++;
      step();
    end
    checks++;
    if (cnt !== TO) begin
      errors++; $display("FAIL timeout_cycles got %0d exp %0d", cnt, TO);
    end
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || sif.s_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_flag got to=%b busy=%b rdy=%b exp 1 0 1",
                         timeout, busy, sif.s_ready);
    end
    gen_frame(sc);
    drive_scores(sc, NC, NC - 1, 0, st);
    show_frame(4, v, am, rok, ena, rdy, lk);
    checks++;
    if (timeout !== 1'b1 || v !== model_digits(sc)) begin
      errors++; $display("FAIL timeout_sticky got to=%b values %h exp 1 %h", timeout, v, model_digits(sc));
    end
    rst = 1'b1;
    step();
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear got %b exp 0", timeout);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_midop();
    frame_t sc;
    bit st;
    logic [NC-1:0][DW-1:0] v;
    logic [3:0] am;
    logic rok, ena, rdy, lk;
    for (int i = 0; i < NC; i++) sc[i] = SW'($urandom_range(31, 1));
    drive_scores(sc, NC, NC - 1, 0, st);
    repeat (3) step();
    rst = 1'b1;
    step();
    checks++;
    if (values !== '0 || argmax !== 4'd0 || {lcd_rst, lcd_en, busy, sif.s_ready, frame_err} !== 5'b0) begin
      errors++; $display("FAIL rst_in_wait got %h/%0d flags=%b exp 0/0 00000",
                         values, argmax, {lcd_rst, lcd_en, busy, sif.s_ready, frame_err});
    end
    rst = 1'b0;
    step();
    gen_frame(sc);
    drive_scores(sc, 6, -1, 1, st);
    rst = 1'b1;
    step();
    checks++;
    if (values !== '0 || {lcd_en, busy, sif.s_ready, timeout} !== 4'b0) begin
      errors++; $display("FAIL rst_in_collect got %h flags=%b exp 0 0000",
                         values, {lcd_en, busy, sif.s_ready, timeout});
    end
    rst = 1'b0;
    step();
    for (int i = 0; i < NC; i++) sc[i] = SW'($urandom_range(200, 1));
    drive_scores(sc, NC, NC - 1, 0, st);
    show_frame(6, v, am, rok, ena, rdy, lk);
    checks++;
    if (v !== model_digits(sc) || am !== model_argmax(sc)) begin
      errors++; $display("FAIL rst_next_frame got %h/%0d exp %h/%0d",
                         v, am, model_digits(sc), model_argmax(sc));
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired before bench completion");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    lcd_done    = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    sif.s_score = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_early_last();
    test_no_last();
    test_back_to_back();
    test_timeout();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_score_buffer.md
Name: lcd_score_buffer

Overview:
- Collects the 10 class scores streamed out of the BNN output layer and saturates each to a 5-bit digit.
- Double-buffers the scores and presents them as a stable packed array to the LCD controller.
- Sequences the controller through one clear-and-display pass per frame: drives its reset/enable, waits for its done, then releases.
- Also reports the argmax class and frame/timeout error flags for debug.

Parameters:
- NUM_CLASSES, 10, scores per frame (index width fixed at 4 bits, so NUM_CLASSES ≤ 16)
- SCORE_W, 16, width of incoming popcount score
- DIGIT_W, 5, width of each displayed digit
- TIMEOUT_CYC, 1024, max cycles to wait for lcd_done before aborting

Ports:
- clk  in  1  system clock
- rst  in  1  reset; the only reset in the block (see Behaviour, Reset)
- s_valid  in  1  upstream score valid
- s_ready  out  1  block accepts a score this cycle
- s_score  in  SCORE_W  unsigned class score
- s_last  in  1  marks final score of a frame
- values  out  NUM_CLASSES x DIGIT_W  packed digits to the LCD controller; entry i = class i
- lcd_rst  out  1  one-cycle clear request to the LCD controller
- lcd_en  out  1  enable to the LCD controller
- lcd_done  in  1  LCD controller finished (level, may stay high)
- busy  out  1  high while not in COLLECT
- argmax  out  4  index of highest score of last displayed frame
- frame_err  out  1  one-cycle pulse on malformed frame
- timeout  out  1  sticky, set on lcd_done timeout, cleared by rst

Behaviour:
- Reset: one clock; reset is synchronous and active-high (rst sampled on rising clk only). All outputs are registered and reset to 0: values, lcd_rst, lcd_en, argmax, frame_err, timeout. s_ready also resets to 0. Internal state resets to COLLECT with idx = 0 and the shadow buffer cleared. s_ready goes to 1 on the first cycle after rst deasserts.
- Transfer rule: a transfer occurs when s_valid && s_ready at a rising edge.
- Saturation: the stored digit is min(s_score, 2^DIGIT_W-1), so 0..31 passes through and anything ≥ 32 becomes 31. Comparison is full SCORE_W unsigned.
- Argmax: a running max uses the unsaturated score with a strict greater-than, so the earliest index wins ties. Index 0 always initialises the max.
- State COLLECT: s_ready = 1.
  - Each transfer writes the digit to shadow[idx], updates the running max, and does idx++.
  - s_last on a transfer with idx < NUM_CLASSES-1 → frame_err pulse next cycle, frame discarded, idx = 0, running max cleared. Stays in COLLECT.
  - Transfer with idx == NUM_CLASSES-1 → frame complete whether or not s_last is set. If s_last = 0, also pulse frame_err; the next score starts a new frame. Go to LOAD.
- State LOAD (1 cycle): s_ready = 0. Copy shadow → values and running argmax → argmax. Assert lcd_rst = 1 and lcd_en = 1. Go to WAIT.
- State WAIT: lcd_rst = 0, lcd_en = 1, s_ready = 0. A cycle counter starts at 0.
  - lcd_done == 1 → lcd_en = 0 next cycle, go to COLLECT.
  - counter reaches TIMEOUT_CYC-1 without lcd_done → lcd_en = 0, timeout = 1, go to COLLECT.
  - lcd_done is ignored in the LOAD cycle, because the controller's previous done may still be high until it sees lcd_rst.
- Latency: frame completes at edge N → values valid and lcd_rst/lcd_en high from edge N+1. Earliest next accept is the cycle after lcd_en drops.
- values is stable throughout LOAD/WAIT and is held until the next LOAD.
- busy = (state != COLLECT).
- Reset mid-operation (any state): rst returns to COLLECT with all outputs 0, the partial frame lost, and timeout cleared.
- Simultaneous: s_last with the NUM_CLASSES-th transfer is the normal case, with no error. rst has priority over everything.

Test Plan:
- Scores 0..9 streamed back-to-back with s_last on index 9 → values = {9,8,...,0}, argmax = 9, lcd_rst high exactly 1 cycle, lcd_en high from the next edge. Force lcd_done = 1 after 20 cycles → lcd_en low next cycle, s_ready = 1.
- Scores {5,40,40,3,100,0,0,0,0,7} → digits {5,31,31,3,31,0,0,0,0,7}, argmax = 4. Repeat with 40 at index 1 as the maximum → argmax = 1 (first of ties).
- s_last asserted on the 4th score → frame_err 1-cycle pulse, no lcd_en. The following clean 10-score frame displays correctly.
- 10 scores with s_last never asserted → frame_err pulse and display still occurs. s_valid with gaps and random stalls → identical values.
- lcd_done held 0 → lcd_en drops after exactly TIMEOUT_CYC cycles in WAIT and timeout = 1 (sticky). Then rst → timeout = 0.
- rst asserted in WAIT and again after 6 of 10 scores → all outputs 0 next edge. A subsequent full frame starts at index 0.
